// File: rtl/game_lcd_pkg.sv
// Shared definitions for the character-LCD controller.
// Holds the register map addresses, STATUS/CONTROL/DATA bit positions and the
// sequencer state encoding, plus the rule deciding which commands need the
// long execute wait.
package game_lcd_pkg;

    // Register map (word addresses on the 2-bit bus address).
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_RSVD    = 2'd3;

    // STATUS bit indices; the FIFO level occupies [STAT_LVL_LSB +: 4].
    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_LVL_LSB = 4;

    // CONTROL and DATA bit indices.
    localparam int CTRL_IEN = 0;
    localparam int DATA_RS  = 8;

    typedef enum logic [2:0] {
        ST_POR   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_WAIT  = 3'd5
    } lcd_state_t;

    // Clear display (0x01) and return home (0x02/0x03) are the slow
    // instructions; everything else, including all data writes, is fast.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/game_lcd_ctrl_if.sv
// Host register bus of the LCD controller.
// Signals: chipselect, address[1:0], write_n, writedata[15:0] (host -> ctrl),
//          readdata[15:0], irq (ctrl -> host).
// Handshake: there is no ready/wait; a write is taken on every rising clock
// edge where chipselect=1 and write_n=0. readdata is a registered copy of the
// register selected by address at the previous edge, refreshed every cycle
// whether or not chipselect is high, so reads have no side effects.
interface game_lcd_ctrl_if;
    logic        chipselect;
    logic [1:0]  address;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    modport master (output chipselect, address, write_n, writedata,
                    input  readdata, irq);
    modport slave  (input  chipselect, address, write_n, writedata,
                    output readdata, irq);
endinterface

// File: rtl/game_lcd_fifo.sv
// Synchronous command FIFO with first-word fall-through read data.
// Ports: clk, rst_n (async, active low); i_push/i_wdata write side;
//        i_pop/o_rdata read side; o_full, o_empty, o_level occupancy.
// Push while full and pop while empty are ignored. Full is judged on the
// current level only, so a pop in the same cycle does not make room.
module game_lcd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/game_lcd_ctrl.sv
// HD44780-style character LCD controller with a host register interface.
// Ports: clk, reset_n (async, active low); bus (register bus, slave side);
//        lcd_rs, lcd_rw, lcd_en, lcd_data[7:0] to the panel;
//        o_dbg_state exposes the sequencer state.
// Host writes to DATA are queued as {rs, byte}; the sequencer waits out the
// panel power-up, then plays each entry as setup / EN pulse / hold / execute
// wait. irq signals "controller idle" when enabled.
module game_lcd_ctrl
    import game_lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int POR_CYC    = 750000,
    parameter int SETUP_CYC  = 2,
    parameter int EN_CYC     = 12,
    parameter int HOLD_CYC   = 2,
    parameter int CMD_CYC    = 2000,
    parameter int CLR_CYC    = 80000
) (
    input  logic             clk,
    input  logic             reset_n,
    game_lcd_ctrl_if.slave   bus,
    output logic             lcd_rs,
    output logic             lcd_rw,
    output logic             lcd_en,
    output logic [7:0]       lcd_data,
    output lcd_state_t       o_dbg_state
);
    localparam int CNT_MAX = (POR_CYC > CLR_CYC) ? POR_CYC : CLR_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int LW      = $clog2(FIFO_DEPTH + 1);

    lcd_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_lcd_en;
    logic          r_lcd_rs;
    logic [7:0]    r_lcd_data;
    logic          r_ovf;
    logic          r_ien;
    logic [15:0]   r_readdata;

    logic          w_wr;
    logic          w_push;
    logic          w_pop;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic          w_busy;
    logic          w_cnt_done;
    logic [8:0]    w_fifo_rdata;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [LW-1:0] w_fifo_level;
    logic [3:0]    w_level4;
    logic [15:0]   w_status;
    logic [15:0]   w_rd_mux;
    logic          w_unused;

    assign w_wr      = bus.chipselect && !bus.write_n;
    assign w_push    = w_wr && (bus.address == ADDR_DATA);
    assign w_ovf_set = w_push && w_fifo_full;
    assign w_ovf_clr = w_wr && (bus.address == ADDR_STATUS) && bus.writedata[STAT_OVF];
    assign w_pop     = (r_state == ST_IDLE) && !w_fifo_empty;
    assign w_busy    = (r_state != ST_IDLE) || !w_fifo_empty;
    // Each timed state is entered with its full cycle count and exits on the
    // cycle the count reaches 1, so a load of N gives exactly N cycles.
    assign w_cnt_done = (r_cnt <= CW'(1));
    assign w_level4   = 4'(w_fifo_level);
    assign w_unused   = ^bus.writedata[15:9];

    game_lcd_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_push),
        .i_wdata (bus.writedata[8:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    always_comb begin
        w_status                         = '0;
        w_status[STAT_BUSY]              = w_busy;
        w_status[STAT_FULL]              = w_fifo_full;
        w_status[STAT_OVF]               = r_ovf;
        w_status[STAT_LVL_LSB +: 4]      = w_level4;
    end

    always_comb begin
        w_rd_mux = '0;
        case (bus.address)
            ADDR_STATUS:  w_rd_mux = w_status;
            ADDR_CONTROL: w_rd_mux[CTRL_IEN] = r_ien;
            default:      w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf      <= 1'b0;
            r_ien      <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
            // A host clear beats an overflow landing in the same cycle.
            if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end else if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
            if (w_wr && (bus.address == ADDR_CONTROL)) begin
                r_ien <= bus.writedata[CTRL_IEN];
            end
        end
    end

    // Sequencer: LCD pins are registered here and only rs/data change on a
    // pop, so they stay stable through setup, pulse, hold and wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_POR;
            r_cnt      <= CW'(POR_CYC);
            r_lcd_en   <= 1'b0;
            r_lcd_rs   <= 1'b0;
            r_lcd_data <= 8'h00;
        end else begin
            case (r_state)
                ST_POR: begin
                    if (w_cnt_done) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_lcd_rs   <= w_fifo_rdata[DATA_RS];
                        r_lcd_data <= w_fifo_rdata[7:0];
                        r_state    <= ST_SETUP;
                        r_cnt      <= CW'(SETUP_CYC);
                    end
                end
                ST_SETUP: begin
                    if (w_cnt_done) begin
                        r_lcd_en <= 1'b1;
                        r_state  <= ST_PULSE;
                        r_cnt    <= CW'(EN_CYC);
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_PULSE: begin
                    if (w_cnt_done) begin
                        r_lcd_en <= 1'b0;
                        r_state  <= ST_HOLD;
                        r_cnt    <= CW'(HOLD_CYC);
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (w_cnt_done) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= is_long_cmd(r_lcd_rs, r_lcd_data) ? CW'(CLR_CYC) : CW'(CMD_CYC);
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (w_cnt_done) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state  <= ST_POR;
                    r_cnt    <= CW'(POR_CYC);
                    r_lcd_en <= 1'b0;
                end
            endcase
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.irq      = r_ien & ~w_busy;
    assign lcd_rs       = r_lcd_rs;
    assign lcd_rw       = 1'b0;
    assign lcd_en       = r_lcd_en;
    assign lcd_data     = r_lcd_data;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_game_lcd_ctrl.sv
// Self-checking bench for game_lcd_ctrl with short timing parameters.
// The reference model treats the controller as a serial resource: each
// accepted entry is popped at the later of "one edge after its push" and
// "one edge after the previous transfer finished", and occupies
// SETUP+EN+HOLD+execute-wait cycles. The FIFO accepts a push only while fewer
// than DEPTH accepted entries are still waiting to be popped.
module tb_game_lcd_ctrl;
    import game_lcd_pkg::*;

    localparam int POR   = 10;
    localparam int CMD   = 5;
    localparam int CLR   = 20;
    localparam int SU    = 2;
    localparam int EN    = 3;
    localparam int HD    = 2;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;
    lcd_state_t dbg_state;

    game_lcd_ctrl_if bus ();

    game_lcd_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .POR_CYC    (POR),
        .SETUP_CYC  (SU),
        .EN_CYC     (EN),
        .HOLD_CYC   (HD),
        .CMD_CYC    (CMD),
        .CLR_CYC    (CLR)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_en      (lcd_en),
        .lcd_data    (lcd_data),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- result counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- LCD pin monitor ----------------
    logic [8:0] obs_cmd_q[$];
    int         obs_rise_q[$];
    int         obs_w_q[$];
    int         obs_idx = 0;
    int         unstable_cnt = 0;
    logic       mon_prev_en = 1'b0;
    logic [8:0] mon_cmd = '0;
    int         mon_rise = 0;

    always @(negedge clk) begin
        if (lcd_en === 1'b1 && !mon_prev_en) begin
            mon_rise = cyc;
            mon_cmd  = {lcd_rs, lcd_data};
        end else if (lcd_en === 1'b1 && mon_prev_en && {lcd_rs, lcd_data} !== mon_cmd) begin
            unstable_cnt++;
        end
        if (lcd_en !== 1'b1 && mon_prev_en) begin
            obs_cmd_q.push_back(mon_cmd);
            obs_rise_q.push_back(mon_rise);
            obs_w_q.push_back(cyc - mon_rise);
        end
        mon_prev_en = (lcd_en === 1'b1);
    end

    // ---------------- reference model / scoreboard ----------------
    logic [8:0] exp_q[$];
    int         exp_rise_q[$];
    int         m_push_q[$];
    int         m_pop_q[$];
    int         m_free = 0;

    function automatic int wait_of(input logic [8:0] c);
        return (!c[8] && c[7:0] <= 8'd3) ? CLR : CMD;
    endfunction

    task automatic model_reset(input int base);
        m_free = base + POR + 1;
        m_push_q.delete();
        m_pop_q.delete();
        exp_q.delete();
        exp_rise_q.delete();
    endtask

    task automatic model_push(input logic [8:0] c, input int t);
        int occ;
        int pop;
        occ = 0;
        foreach (m_push_q[i]) begin
            if (m_push_q[i] < t && m_pop_q[i] >= t) occ++;
        end
        if (occ >= DEPTH) return;
        pop = (t + 1 > m_free) ? t + 1 : m_free;
        m_push_q.push_back(t);
        m_pop_q.push_back(pop);
        exp_q.push_back(c);
        exp_rise_q.push_back(pop + SU);
        m_free = pop + SU + EN + HD + wait_of(c) + 1;
    endtask

    function automatic logic [8:0] rand_cmd();
        logic [8:0] c;
        c[8] = 1'($urandom_range(0, 1));
        if (c[8]) c[7:0] = 8'($urandom_range(0, 255));
        else if ($urandom_range(0, 3) == 0) c[7:0] = 8'($urandom_range(0, 1));
        else c[7:0] = 8'($urandom_range(4, 255));
        return c;
    endfunction

    task automatic check_transfers(input string tag);
        logic [8:0] c;
        int r;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            r = exp_rise_q.pop_front();
            if (obs_idx < obs_cmd_q.size()) begin
                chk({tag, ".cmd"},   obs_cmd_q[obs_idx],  c);
                chk({tag, ".rise"},  obs_rise_q[obs_idx], r);
                chk({tag, ".width"}, obs_w_q[obs_idx],    EN);
                obs_idx++;
            end else begin
                chk({tag, ".missing_cmd"}, obs_cmd_q.size(), obs_idx + 1);
            end
        end
        chk({tag, ".extra_cmds"}, obs_cmd_q.size(), obs_idx);
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic bus_idle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = ADDR_STATUS;
        bus.writedata  = 16'h0000;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d, output int w);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        @(negedge clk);
        w = cyc;
        bus_idle();
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [15:0] d);
        bus.address = a;
        @(negedge clk);
        d = bus.readdata;
        bus.address = ADDR_STATUS;
    endtask

    task automatic wait_until(input int edge_n);
        while (cyc < edge_n) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.irq !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".idle_edge"}, cyc, m_free - 1);
    endtask

    task automatic do_reset(output int base);
        reset_n = 1'b0;
        bus_idle();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        base = cyc;
        model_reset(base);
        obs_idx = obs_cmd_q.size();
    endtask

    task automatic check_por(input int base);
        wait_until(base + 2);
        chk("por.status_early", bus.readdata, 16'h0001);
        wait_until(base + POR);
        chk("por.status_last", bus.readdata, 16'h0001);
        chk("por.lcd_en", lcd_en, 1'b0);
        wait_until(base + POR + 1);
        chk("por.status_done", bus.readdata, 16'h0000);
        chk("por.irq_ien_off", bus.irq, 1'b0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int base;
        int w;
        int n;
        logic [8:0]  c;
        logic [15:0] rd;

        bus_idle();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.readdata", bus.readdata, 16'h0000);
        chk("rst.lcd_en",   lcd_en,   1'b0);
        chk("rst.lcd_rs",   lcd_rs,   1'b0);
        chk("rst.lcd_data", lcd_data, 8'h00);
        chk("rst.lcd_rw",   lcd_rw,   1'b0);
        chk("rst.irq",      bus.irq,  1'b0);
        reset_n = 1'b1;
        base = cyc;
        model_reset(base);
        check_por(base);

        bus_write(ADDR_CONTROL, 16'h0001, w);
        chk("ien.irq_idle", bus.irq, 1'b1);

        // Single data write: pins latched the edge after the write.
        bus_write(ADDR_DATA, 16'h0141, w);
        model_push(9'h141, w);
        chk("d141.irq_busy", bus.irq, 1'b0);
        @(negedge clk);
        chk("d141.lcd_rs",   lcd_rs,   1'b1);
        chk("d141.lcd_data", lcd_data, 8'h41);
        chk("d141.lcd_en",   lcd_en,   1'b0);
        wait_idle("d141");
        check_transfers("d141");

        // Clear display takes the long wait, function set the short one.
        bus_write(ADDR_DATA, 16'h0001, w);
        model_push(9'h001, w);
        wait_idle("clr01");
        check_transfers("clr01");
        bus_write(ADDR_DATA, 16'h0038, w);
        model_push(9'h038, w);
        wait_idle("cmd38");
        check_transfers("cmd38");
        chk("cmd38.lcd_rw", lcd_rw, 1'b0);

        // Register map, reserved address, ien control of irq.
        read_reg(ADDR_DATA, rd);
        chk("map.data_reads_zero", rd, 16'h0000);
        read_reg(ADDR_CONTROL, rd);
        chk("map.control_ien", rd, 16'h0001);
        bus_write(ADDR_RSVD, 16'hFFFF, w);
        read_reg(ADDR_RSVD, rd);
        chk("map.rsvd_reads_zero", rd, 16'h0000);
        read_reg(ADDR_CONTROL, rd);
        chk("map.rsvd_write_ignored", rd, 16'h0001);
        read_reg(ADDR_STATUS, rd);
        chk("map.status_idle", rd, 16'h0000);
        bus_write(ADDR_CONTROL, 16'h0000, w);
        chk("ien0.irq_low", bus.irq, 1'b0);
        read_reg(ADDR_CONTROL, rd);
        chk("ien0.control", rd, 16'h0000);
        bus_write(ADDR_CONTROL, 16'h0001, w);
        chk("ien1.irq_high", bus.irq, 1'b1);

        // Random bursts with random gaps.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(3, 8);
            for (int i = 0; i < n; i++) begin
                c = rand_cmd();
                bus_write(ADDR_DATA, {7'b0, c}, w);
                model_push(c, w);
                if (i == 0) chk("rand.irq_busy", bus.irq, 1'b0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_idle("rand");
            check_transfers("rand");
        end

        // Nine writes during power-up: eight queued, one dropped.
        do_reset(base);
        for (int i = 0; i < 9; i++) begin
            c = rand_cmd();
            bus_write(ADDR_DATA, {7'b0, c}, w);
            model_push(c, w);
        end
        @(negedge clk);
        chk("ovf.status_full", bus.readdata, 16'h0087);
        chk("ovf.lcd_en_por", lcd_en, 1'b0);
        bus_write(ADDR_STATUS, 16'h0004, w);
        @(negedge clk);
        chk("ovf.status_cleared", bus.readdata, 16'h0071);
        bus_write(ADDR_CONTROL, 16'h0001, w);
        chk("ovf.irq_busy", bus.irq, 1'b0);
        wait_idle("ovf");
        check_transfers("ovf");

        // Reset in the middle of an EN pulse with entries still queued.
        bus_write(ADDR_DATA, 16'h0141, w);
        bus_write(ADDR_DATA, 16'h0142, w);
        bus_write(ADDR_DATA, 16'h0143, w);
        n = 0;
        while (lcd_en !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("abort.en_seen", lcd_en, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort.en_drop",   lcd_en,       1'b0);
        chk("abort.readdata",  bus.readdata, 16'h0000);
        chk("abort.lcd_data",  lcd_data,     8'h00);
        do_reset(base);
        check_por(base);
        wait_until(base + POR + 6);
        chk("abort.no_transfer", obs_cmd_q.size(), obs_idx);
        chk("abort.lcd_en_idle", lcd_en, 1'b0);

        chk("stable.lcd_bus", unstable_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case a sequence step stalls.
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "timeout");
    end
endmodule
